// File: rtl/line_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_cmd_pkg
// Purpose  : Shared definitions for the line command stream. Holds the
//            opcodes, the sequencer state encoding and helpers for slicing
//            the 20-bit point field {x[9:0], y[9:0]} out of a command word.
//            LineEngine command builders import this package as well.
// Revision : 1.0 - initial release
// ============================================================================
package line_cmd_pkg;

  // Opcodes carried in command word bits [31:24]
  localparam logic [7:0] OP_LINE = 8'h01;
  localparam logic [7:0] OP_END  = 8'h00;

  localparam int LINE_CNT_W = 16;

  // Point field layout inside a 32-bit point word
  localparam int PT_W     = 20;
  localparam int PT_X_MSB = 19;
  localparam int PT_X_LSB = 10;
  localparam int PT_Y_MSB = 9;
  localparam int PT_Y_LSB = 0;

  // Sequencer state encoding
  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] S_IDLE = 4'd0;   // waiting for start
  localparam logic [ST_W-1:0] S_OP   = 4'd1;   // fetch opcode word
  localparam logic [ST_W-1:0] S_COL  = 4'd2;   // fetch color word
  localparam logic [ST_W-1:0] S_P0   = 4'd3;   // fetch point0 word
  localparam logic [ST_W-1:0] S_P1   = 4'd4;   // fetch point1 word
  localparam logic [ST_W-1:0] S_SCOL = 4'd5;   // present color to engine
  localparam logic [ST_W-1:0] S_SP0  = 4'd6;   // present point0
  localparam logic [ST_W-1:0] S_SP1  = 4'd7;   // present point1
  localparam logic [ST_W-1:0] S_TRIG = 4'd8;   // start-draw strobe
  localparam logic [ST_W-1:0] S_GAP  = 4'd9;   // let engine drop ready
  localparam logic [ST_W-1:0] S_WAIT = 4'd10;  // wait for engine idle
  localparam logic [ST_W-1:0] S_DONE = 4'd11;  // END consumed

  function automatic logic [PT_W-1:0] pt_field(input logic [31:0] word);
    return word[PT_W-1:0];
  endfunction

  function automatic logic [9:0] pt_x(input logic [PT_W-1:0] pt);
    return pt[PT_X_MSB:PT_X_LSB];
  endfunction

  function automatic logic [9:0] pt_y(input logic [PT_W-1:0] pt);
    return pt[PT_Y_MSB:PT_Y_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : line_cmd_sequencer
// Purpose  : Pops command words from the graphics command FIFO, decodes
//            LINE / END, and replays the LineEngine load handshake
//            (color, point0, point1, trigger) one line at a time.
// Ports    : clk, rst (async, active-low), start      - control in
//            busy, done, error, line_count            - status out
//            cmd_data, cmd_valid / cmd_ready          - command FIFO side
//            LE_ready                                 - engine idle in
//            LE_color, LE_point, LE_*_valid,
//            LE_trigger                               - engine load side
// Revision : 1.0 - initial release
// ============================================================================
module line_cmd_sequencer
  import line_cmd_pkg::*;
#(
  parameter int CNT_W = LINE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] line_count,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             LE_ready,
  output logic [31:0]      LE_color,
  output logic [PT_W-1:0]  LE_point,
  output logic             LE_color_valid,
  output logic             LE_point0_valid,
  output logic             LE_point1_valid,
  output logic             LE_trigger
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;

  logic [31:0]     r_color;
  logic [PT_W-1:0] r_p0;
  logic [PT_W-1:0] r_p1;

  logic       w_hs;
  logic [7:0] w_opcode;
  logic       w_illegal;

  logic w_busy_nxt;
  logic w_done_nxt;
  logic w_cmd_ready_nxt;
  logic w_col_v_nxt;
  logic w_p0_v_nxt;
  logic w_p1_v_nxt;
  logic w_trig_nxt;

  assign w_hs      = cmd_valid & cmd_ready;
  assign w_opcode  = cmd_data[31:24];
  assign w_illegal = (w_opcode != OP_LINE) && (w_opcode != OP_END);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_OP;
      S_OP: begin
        if (w_hs) begin
          if (w_opcode == OP_LINE)     w_state_nxt = S_COL;
          else if (w_opcode == OP_END) w_state_nxt = S_DONE;
          // illegal opcode: word dropped, keep fetching opcodes
        end
      end
      S_COL:  if (w_hs) w_state_nxt = S_P0;
      S_P0:   if (w_hs) w_state_nxt = S_P1;
      S_P1:   if (w_hs) w_state_nxt = S_SCOL;
      S_SCOL: if (LE_ready) w_state_nxt = S_SP0;
      S_SP0:  w_state_nxt = S_SP1;
      S_SP1:  w_state_nxt = S_TRIG;
      S_TRIG: w_state_nxt = S_GAP;
      // Engine only lowers ready the cycle after trigger, so skip one cycle
      // before trusting LE_ready again.
      S_GAP:  w_state_nxt = S_WAIT;
      S_WAIT: if (LE_ready) w_state_nxt = S_OP;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_cmd_ready_nxt = (w_state_nxt == S_OP) || (w_state_nxt == S_COL) ||
                      (w_state_nxt == S_P0) || (w_state_nxt == S_P1);
    w_col_v_nxt     = (w_state_nxt == S_SCOL);
    w_p0_v_nxt      = (w_state_nxt == S_SP0);
    w_p1_v_nxt      = (w_state_nxt == S_SP1);
    w_trig_nxt      = (w_state_nxt == S_TRIG);
  end

  // Registered outputs, operand registers and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      cmd_ready       <= 1'b0;
      LE_color_valid  <= 1'b0;
      LE_point0_valid <= 1'b0;
      LE_point1_valid <= 1'b0;
      LE_trigger      <= 1'b0;
      LE_color        <= '0;
      LE_point        <= '0;
      r_color         <= '0;
      r_p0            <= '0;
      r_p1            <= '0;
      error           <= 1'b0;
      line_count      <= '0;
    end else begin
      busy            <= w_busy_nxt;
      done            <= w_done_nxt;
      cmd_ready       <= w_cmd_ready_nxt;
      LE_color_valid  <= w_col_v_nxt;
      LE_point0_valid <= w_p0_v_nxt;
      LE_point1_valid <= w_p1_v_nxt;
      LE_trigger      <= w_trig_nxt;

      if (w_hs && (r_state == S_COL)) r_color <= cmd_data;
      if (w_hs && (r_state == S_P0))  r_p0    <= pt_field(cmd_data);
      if (w_hs && (r_state == S_P1))  r_p1    <= pt_field(cmd_data);

      // Engine-facing operands change only on entry to a send state and
      // otherwise keep the last value presented.
      if (w_col_v_nxt) LE_color <= r_color;
      if (w_p0_v_nxt)  LE_point <= r_p0;
      if (w_p1_v_nxt)  LE_point <= r_p1;

      if ((r_state == S_IDLE) && start) begin
        error      <= 1'b0;
        line_count <= '0;
      end else begin
        if ((r_state == S_OP) && w_hs && w_illegal) error <= 1'b1;
        if ((r_state == S_TRIG) && (line_count != {CNT_W{1'b1}}))
          line_count <= line_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/line_cmd_sequencer.md
Name: line_cmd_sequencer

Overview:
Command-stream controller that feeds the line engine. Pops 32-bit words from the graphics command FIFO (valid/ready), decodes LINE and END commands, and replays the line engine's load handshake: color, then point0, point1, trigger. Waits for the engine to finish each line before fetching the next. Sits between the command FIFO and LineEngine; owns LE_color, LE_point, the three *_valid strobes and LE_trigger.

Parameters:
OP_LINE, 8'h01, opcode in cmd_data[31:24] starting a 4-word line command
OP_END, 8'h00, opcode ending the stream
CNT_W, 16, width of line_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins stream processing from IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when END is consumed
error  out  1  sticky; an illegal opcode was seen; cleared by accepted start
line_count  out  CNT_W  lines triggered since last accepted start; saturates
cmd_data  in  32  command word
cmd_valid  in  1  cmd_data valid
cmd_ready  out  1  word accepted when cmd_valid & cmd_ready at posedge
LE_ready  in  1  line engine idle / accepting loads
LE_color  out  32  color operand
LE_point  out  20  {x[9:0], y[9:0]}
LE_color_valid  out  1  color load strobe
LE_point0_valid  out  1  point0 load strobe
LE_point1_valid  out  1  point1 load strobe
LE_trigger  out  1  start-draw strobe

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output 0, including LE_color, LE_point, line_count, error. Reset mid-line drops all strobes immediately; no partial command resumes.
- Command format: word0 opcode [31:24], [23:0] ignored; LINE adds word1=color, word2=point0 in [19:0], word3=point1 in [19:0]; [31:20] of point words ignored.
- FSM, registered outputs:
  - IDLE: start -> OP; error<=0, line_count<=0. start outside IDLE ignored.
  - OP: cmd_ready=1. On handshake: OP_LINE -> COL; OP_END -> DONE; other -> error<=1, stay in OP (word dropped).
  - COL, P0, P1: cmd_ready=1; on handshake latch word into color / p0 / p1 register, advance. No handshake: hold state indefinitely.
  - S_COL: LE_color=color, LE_color_valid=1. Held until LE_ready sampled 1, then -> S_P0.
  - S_P0: LE_point=p0, LE_point0_valid=1 for exactly one cycle -> S_P1.
  - S_P1: LE_point=p1, LE_point1_valid=1 for exactly one cycle -> TRIG.
  - TRIG: LE_trigger=1 for one cycle; line_count+=1 unless all-ones -> GAP.
  - GAP: one cycle, LE_ready ignored (engine drops ready after trigger) -> WAIT.
  - WAIT: -> OP when LE_ready=1.
  - DONE: done=1 for one cycle -> IDLE.
- cmd_ready is 0 in every state except OP/COL/P0/P1, so no word is consumed while the engine is loading or drawing.
- At most one strobe among color/point0/point1/trigger is high in any cycle.
- LE_color/LE_point hold their last driven value outside the send states.
- Minimum cost per line with a ready engine and continuous cmd_valid: 4 fetch + 1 S_COL + 3 + 1 GAP = 9 cycles plus draw time.

Decomposition:
- Shared package line_cmd_pkg: OP_LINE/OP_END constants, state encoding, point-field slice macros (X=[19:10], Y=[9:0]). LineEngine's command builders also use this package.
- No sub-module: single FSM plus operand registers.

Test Plan:
- Single line: start; words 0x01000000, 0x007F0000, {x0=0,y0=0}, {x1=800,y1=0}, 0x00000000.
  - Required: LE_color=0x007F0000 with color_valid until LE_ready.
  - Then point0_valid with LE_point=0x00000, point1_valid with LE_point=0xC8000, trigger, each one cycle.
  - After LE_ready returns: done pulse, line_count=1, busy=0.
- Stalled FIFO: drop cmd_valid for 5 cycles between word2 and word3.
  - Required: FSM holds in P1, no LE strobe, then completes identically.
- Illegal opcode 0x7A before a LINE.
  - Required: error=1, one word consumed, LINE still drawn, line_count=1.
  - Next start clears error to 0.
- Engine busy: hold LE_ready=0 for 20 cycles while in S_COL, and again in WAIT.
  - Required: LE_color_valid held high throughout S_COL; cmd_ready=0 throughout WAIT.
- Reset mid-draw: rst=0 during S_P1.
  - Required: all outputs 0 asynchronously; after release, state IDLE, start ignored until rst=1.
- Back-to-back: three LINE commands then END.
  - Required: line_count=3, exactly three LE_trigger pulses, no two strobes in the same cycle.
